// File: rtl/amax10_qsys_onchip_memory_dp.sv
// Dual-port Avalon-MM on-chip RAM: two slaves share one array, per-port read pipelines,
// lane-priority write collisions (s1 wins) and an optional post-reset zero-clear sweep.
module amax10_qsys_onchip_memory_dp #(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned DEPTH          = 25000,
   parameter int unsigned ADDR_W         = 15,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clken,
   input  logic                  reset_req,
   input  logic [ADDR_W-1:0]     s1_address,
   input  logic                  s1_chipselect,
   input  logic                  s1_read,
   input  logic                  s1_write,
   input  logic [DATA_W/8-1:0]   s1_byteenable,
   input  logic [DATA_W-1:0]     s1_writedata,
   output logic [DATA_W-1:0]     s1_readdata,
   output logic                  s1_readdatavalid,
   output logic                  s1_waitrequest,
   input  logic [ADDR_W-1:0]     s2_address,
   input  logic                  s2_chipselect,
   input  logic                  s2_read,
   input  logic                  s2_write,
   input  logic [DATA_W/8-1:0]   s2_byteenable,
   input  logic [DATA_W-1:0]     s2_writedata,
   output logic [DATA_W-1:0]     s2_readdata,
   output logic                  s2_readdatavalid,
   output logic                  s2_waitrequest,
   output logic                  init_done
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];

   state_t            r_state;
   logic [IDX_W-1:0]  r_clr_cnt;
   logic              r_init_done;

   logic              r_s1_v1, r_s1_v2, r_s2_v1, r_s2_v2;
   logic [DATA_W-1:0] r_s1_d1, r_s1_d2, r_s2_d1, r_s2_d2;

   logic              w_en, w_wait, w_clr_we;
   logic              w_s1_inr, w_s2_inr;
   logic              w_s1_wr, w_s2_wr, w_s1_rd, w_s2_rd;
   logic [IDX_W-1:0]  w_s1_idx, w_s2_idx;

   // reset_n is folded into the enable so a response already in the output stage
   // is suppressed in the reset cycle and then flushed by the reset edge.
   always_comb begin
      w_en     = reset_n & clken & ~reset_req;
      w_wait   = ~w_en | (r_state != ST_RUN);
      w_clr_we = reset_n & clken & (r_state == ST_CLEAR);

      w_s1_inr = {1'b0, s1_address} < DEPTH_L;
      w_s2_inr = {1'b0, s2_address} < DEPTH_L;
      w_s1_idx = s1_address[IDX_W-1:0];
      w_s2_idx = s2_address[IDX_W-1:0];

      w_s1_wr  = s1_chipselect & s1_write & ~w_wait & w_s1_inr;
      w_s2_wr  = s2_chipselect & s2_write & ~w_wait & w_s2_inr;
      w_s1_rd  = s1_chipselect & s1_read & ~s1_write & ~w_wait;
      w_s2_rd  = s2_chipselect & s2_read & ~s2_write & ~w_wait;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         r_clr_cnt   <= '0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               if (clken) begin
                  if (r_clr_cnt == LAST_IDX) begin
                     r_state     <= ST_RUN;
                     r_init_done <= 1'b1;
                  end else begin
                     r_clr_cnt <= r_clr_cnt + 1'b1;
                  end
               end
            end
            ST_RUN:  r_init_done <= 1'b1;
            default: r_state     <= ST_CLEAR;
         endcase
      end
   end

   // s2 lanes are written first so s1 lanes override them on a same-address collision.
   always_ff @(posedge clk) begin
      if (w_clr_we)
         r_mem[r_clr_cnt] <= '0;
      if (w_s2_wr)
         for (int unsigned b = 0; b < NB; b++)
            if (s2_byteenable[b])
               r_mem[w_s2_idx][8*b +: 8] <= s2_writedata[8*b +: 8];
      if (w_s1_wr)
         for (int unsigned b = 0; b < NB; b++)
            if (s1_byteenable[b])
               r_mem[w_s1_idx][8*b +: 8] <= s1_writedata[8*b +: 8];
   end

   // Read pipelines advance only on enabled cycles; reads sample pre-edge (old) data.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_s1_v1 <= 1'b0;
         r_s1_v2 <= 1'b0;
         r_s1_d1 <= '0;
         r_s1_d2 <= '0;
         r_s2_v1 <= 1'b0;
         r_s2_v2 <= 1'b0;
         r_s2_d1 <= '0;
         r_s2_d2 <= '0;
      end else if (w_en) begin
         r_s1_v1 <= w_s1_rd;
         r_s1_v2 <= r_s1_v1;
         if (w_s1_rd)
            r_s1_d1 <= w_s1_inr ? r_mem[w_s1_idx] : '0;
         if (r_s1_v1)
            r_s1_d2 <= r_s1_d1;
         r_s2_v1 <= w_s2_rd;
         r_s2_v2 <= r_s2_v1;
         if (w_s2_rd)
            r_s2_d1 <= w_s2_inr ? r_mem[w_s2_idx] : '0;
         if (r_s2_v1)
            r_s2_d2 <= r_s2_d1;
      end
   end

   always_comb begin
      s1_waitrequest = w_wait;
      s2_waitrequest = w_wait;
      init_done      = r_init_done;
      if (READ_LATENCY == 2) begin
         s1_readdatavalid = r_s1_v2 & w_en;
         s1_readdata      = r_s1_d2;
         s2_readdatavalid = r_s2_v2 & w_en;
         s2_readdata      = r_s2_d2;
      end else begin
         s1_readdatavalid = r_s1_v1 & w_en;
         s1_readdata      = r_s1_d1;
         s2_readdatavalid = r_s2_v1 & w_en;
         s2_readdata      = r_s2_d1;
      end
   end

endmodule
